// File: rtl/large_matrix_mult_pkg.sv
// Shared constants and types for the streaming square matrix multiplier.
package large_matrix_mult_pkg;

   localparam int MM_WIDTH        = 8;
   localparam int MM_NUM_ELEMENTS = 4;
   localparam int MM_MATRIX_WIDTH = 4;

   localparam int CNT_W = $clog2(MM_MATRIX_WIDTH * MM_MATRIX_WIDTH);
   localparam int ROW_W = $clog2(MM_MATRIX_WIDTH);

   typedef enum logic [1:0] {
      LOAD_A,
      LOAD_B,
      COMPUTE,
      DRAIN
   } mm_state_t;

endpackage

// File: rtl/large_matrix_mult_dot.sv
// Combinational N-way dot product of a row of A and a column of B.
module mm_dot
   import large_matrix_mult_pkg::*;
#(
   parameter int WIDTH = MM_WIDTH,
   parameter int N     = MM_MATRIX_WIDTH
) (
   input  logic [N*WIDTH-1:0] row_i,
   input  logic [N*WIDTH-1:0] col_i,
   output logic [WIDTH-1:0]   dot_o
);

   localparam int SUM_W = 2 * WIDTH + $clog2(N);

   logic [SUM_W-1:0] acc;
   logic             unused_hi;

   // Sum is kept at full precision; only the low WIDTH bits leave the block.
   always_comb begin
      acc = '0;
      for (int k = 0; k < N; k++) begin
         acc = acc + (SUM_W'(row_i[k*WIDTH +: WIDTH]) *
                      SUM_W'(col_i[k*WIDTH +: WIDTH]));
      end
   end

   assign dot_o     = acc[WIDTH-1:0];
   assign unused_hi = ^acc[SUM_W-1:WIDTH];

endmodule

// File: rtl/large_matrix_mult.sv
// Streaming C = A x B: load A and B by rows, compute one element per cycle,
// then drain C by rows.
module large_matrix_mult
   import large_matrix_mult_pkg::*;
#(
   parameter int WIDTH        = MM_WIDTH,
   parameter int NUM_ELEMENTS = MM_NUM_ELEMENTS,
   parameter int MATRIX_WIDTH = MM_MATRIX_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic [NUM_ELEMENTS*WIDTH-1:0] Res,
   input  logic [NUM_ELEMENTS*WIDTH-1:0] wdata,
   input  logic                          write_en,
   input  logic                          read_en,
   output logic                          write_ready,
   output logic                          read_ready
);

   localparam int N     = MATRIX_WIDTH;
   localparam int RW    = N * WIDTH;
   localparam int C_W   = $clog2(N * N);
   localparam int R_W   = $clog2(N);

   localparam logic [C_W-1:0] LAST_ROW = C_W'(N - 1);
   localparam logic [C_W-1:0] LAST_IDX = C_W'(N * N - 1);

   mm_state_t      state_q, state_d;
   logic [C_W-1:0] cnt_q, cnt_d;
   logic [RW-1:0]  a_q [N];
   logic [RW-1:0]  a_d [N];
   logic [RW-1:0]  b_q [N];
   logic [RW-1:0]  b_d [N];
   logic [RW-1:0]  c_q [N];
   logic [RW-1:0]  c_d [N];

   logic [R_W-1:0]   row_sel;
   logic [R_W-1:0]   ci;
   logic [R_W-1:0]   cj;
   logic [RW-1:0]    b_col;
   logic [WIDTH-1:0] dot;

   // Index is row-major with N a power of two: high half row, low half column.
   assign row_sel = cnt_q[R_W-1:0];
   assign ci      = cnt_q[C_W-1 -: R_W];
   assign cj      = cnt_q[R_W-1:0];

   always_comb begin
      b_col = '0;
      for (int k = 0; k < N; k++) begin
         b_col[k*WIDTH +: WIDTH] = b_q[k][cj*WIDTH +: WIDTH];
      end
   end

   mm_dot #(
      .WIDTH (WIDTH),
      .N     (N)
   ) u_dot (
      .row_i (a_q[ci]),
      .col_i (b_col),
      .dot_o (dot)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      write_ready = 1'b0;
      read_ready  = 1'b0;
      Res         = '0;
      unique case (state_q)
         LOAD_A: begin
            write_ready = 1'b1;
            if (write_en) begin
               a_d[row_sel] = wdata;
               if (cnt_q == LAST_ROW) begin
                  cnt_d   = '0;
                  state_d = LOAD_B;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         LOAD_B: begin
            write_ready = 1'b1;
            if (write_en) begin
               b_d[row_sel] = wdata;
               if (cnt_q == LAST_ROW) begin
                  cnt_d   = '0;
                  state_d = COMPUTE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         COMPUTE: begin
            c_d[ci][cj*WIDTH +: WIDTH] = dot;
            if (cnt_q == LAST_IDX) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            read_ready = 1'b1;
            Res        = c_q[row_sel];
            if (read_en) begin
               if (cnt_q == LAST_ROW) begin
                  cnt_d   = '0;
                  state_d = LOAD_A;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = LOAD_A;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LOAD_A;
         cnt_q   <= '0;
         for (int r = 0; r < N; r++) begin
            a_q[r] <= '0;
            b_q[r] <= '0;
            c_q[r] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int r = 0; r < N; r++) begin
            a_q[r] <= a_d[r];
            b_q[r] <= b_d[r];
            c_q[r] <= c_d[r];
         end
      end
   end

endmodule

// File: tb/tb_large_matrix_mult.sv
// Self-checking bench for large_matrix_mult: table of jobs plus corner sequences.
module tb_large_matrix_mult;

   typedef logic [3:0][31:0] mat_t;

   typedef struct {
      mat_t  a;
      mat_t  b;
      mat_t  c;
      string nm;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Res;
   logic [31:0] wdata;
   logic        write_en;
   logic        read_en;
   logic        write_ready;
   logic        read_ready;

   int tests = 0;
   int fails = 0;

   vec_t tbl [8];

   large_matrix_mult dut (
      .clk         (clk),
      .reset       (reset),
      .Res         (Res),
      .wdata       (wdata),
      .write_en    (write_en),
      .read_en     (read_en),
      .write_ready (write_ready),
      .read_ready  (read_ready)
   );

   always #5 clk = ~clk;

   function automatic mat_t model(mat_t a, mat_t b);
      mat_t c;
      int   s;
      c = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
               s += int'(a[i][k*8 +: 8]) * int'(b[k][j*8 +: 8]);
            end
            c[i][j*8 +: 8] = 8'(s % 256);
         end
      end
      return c;
   endfunction

   function automatic mat_t rand_mat();
      mat_t m;
      for (int r = 0; r < 4; r++) begin
         m[r] = $urandom;
      end
      return m;
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(mat_t a, mat_t b, string nm);
      for (int r = 0; r < 4; r++) begin
         chk($sformatf("%s_wr_a%0d", nm, r), 32'(write_ready), 32'd1);
         write_en = 1'b1;
         wdata    = a[r];
         tick();
      end
      for (int r = 0; r < 4; r++) begin
         chk($sformatf("%s_wr_b%0d", nm, r), 32'(write_ready), 32'd1);
         write_en = 1'b1;
         wdata    = b[r];
         tick();
      end
      write_en = 1'b0;
      wdata    = '0;
   endtask

   task automatic wait_rr(string nm);
      int n;
      n = 0;
      while (!read_ready && n < 200) begin
         tick();
         n++;
      end
      chk($sformatf("%s_latency", nm), 32'(n), 32'd16);
   endtask

   task automatic drain(mat_t c, string nm);
      for (int r = 0; r < 4; r++) begin
         chk($sformatf("%s_rr%0d", nm, r), 32'(read_ready), 32'd1);
         chk($sformatf("%s_row%0d", nm, r), Res, c[r]);
         read_en = 1'b1;
         tick();
      end
      read_en = 1'b0;
      chk($sformatf("%s_post_wr", nm), 32'(write_ready), 32'd1);
      chk($sformatf("%s_post_rr", nm), 32'(read_ready), 32'd0);
      chk($sformatf("%s_post_res", nm), Res, 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      write_en = 1'b0;
      read_en  = 1'b0;
      wdata    = '0;

      tbl[0].nm = "ones";
      tbl[0].a  = {4{32'h01010101}};
      tbl[0].b  = {4{32'h01010101}};
      tbl[0].c  = {4{32'h04040404}};
      tbl[1].nm = "ident";
      tbl[1].a  = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
      tbl[1].b  = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
      tbl[1].c  = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
      tbl[2].nm = "wrap23";
      tbl[2].a  = {4{32'h02020202}};
      tbl[2].b  = {4{32'h03030303}};
      tbl[2].c  = {4{32'h18181818}};
      tbl[3].nm = "wrap10";
      tbl[3].a  = {4{32'h10101010}};
      tbl[3].b  = {4{32'h10101010}};
      tbl[3].c  = {4{32'h00000000}};
      for (int v = 4; v < 8; v++) begin
         tbl[v].nm = $sformatf("rand%0d", v);
         tbl[v].a  = rand_mat();
         tbl[v].b  = rand_mat();
         tbl[v].c  = model(tbl[v].a, tbl[v].b);
      end

      #2;
      chk("rst_wr", 32'(write_ready), 32'd1);
      chk("rst_rr", 32'(read_ready), 32'd0);
      chk("rst_res", Res, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      for (int v = 0; v < 8; v++) begin
         load(tbl[v].a, tbl[v].b, tbl[v].nm);
         wait_rr(tbl[v].nm);
         drain(tbl[v].c, tbl[v].nm);
      end

      // Backpressure with stray writes during compute and drain.
      load(tbl[2].a, tbl[2].b, "bp");
      write_en = 1'b1;
      wdata    = 32'hFFFFFFFF;
      wait_rr("bp");
      for (int t = 0; t < 10; t++) begin
         chk($sformatf("bp_hold_res%0d", t), Res, 32'h18181818);
         chk($sformatf("bp_hold_rr%0d", t), 32'(read_ready), 32'd1);
         tick();
      end
      write_en = 1'b0;
      wdata    = '0;
      drain(tbl[2].c, "bp");

      // Reset pulse in the middle of a computation.
      load(tbl[1].a, tbl[1].b, "mid");
      repeat (5) tick();
      reset = 1'b1;
      #1;
      chk("mid_rst_wr", 32'(write_ready), 32'd1);
      chk("mid_rst_rr", 32'(read_ready), 32'd0);
      chk("mid_rst_res", Res, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      load(tbl[0].a, tbl[0].b, "after_rst");
      wait_rr("after_rst");
      drain(tbl[0].c, "after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
